// File: rtl/ffi_gamma_ctrl.sv
// ffi_gamma_ctrl: gamma-window feed-forward-inhibition controller.
// Frames time into GAMMA_LEN-cycle windows followed by REST_LEN rest cycles.
// Within a window it issues active-low spike requests all-or-nothing against
// a cumulative budget of FFI_MAX spikes, and lets each neuron fire at most once.
module ffi_gamma_ctrl #(
   parameter int unsigned NUM_SPIKES = 8,
   parameter int unsigned FFI_MAX    = 2,
   parameter int unsigned GAMMA_LEN  = 16,
   parameter int unsigned REST_LEN   = 2,
   localparam int unsigned CW        = $clog2(NUM_SPIKES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_l,
   input  logic                  start,
   input  logic [NUM_SPIKES-1:0] should_spike_in_l,
   output logic [NUM_SPIKES-1:0] should_spike_out_l,
   output logic [NUM_SPIKES-1:0] fired_l,
   output logic [CW-1:0]         spike_count,
   output logic                  inhibited,
   output logic                  busy,
   output logic                  gamma_done
);

   localparam int unsigned TW = (GAMMA_LEN > 1) ? $clog2(GAMMA_LEN) : 1;
   localparam int unsigned RW = (REST_LEN > 1) ? $clog2(REST_LEN) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_INTEGRATE,
      S_INHIBIT,
      S_REST
   } state_t;

   state_t                state;
   logic [TW-1:0]         tick;
   logic [RW-1:0]         rtick;

   logic [NUM_SPIKES-1:0] cand;
   logic [CW-1:0]         n_req;
   logic [CW-1:0]         rem;
   logic [CW-1:0]         sum;
   logic                  accept;
   logic                  over;
   logic                  tick_last;
   logic                  rtick_last;

   // Candidate set, its popcount and the all-or-nothing budget decision.
   always_comb begin
      cand  = ~should_spike_in_l & fired_l;
      n_req = '0;
      for (int unsigned i = 0; i < NUM_SPIKES; i++) begin
         n_req = n_req + CW'(cand[i]);
      end
      rem        = CW'(FFI_MAX) - spike_count;
      sum        = spike_count + n_req;
      accept     = (n_req != '0) && (n_req <= rem);
      over       = (n_req > rem);
      tick_last  = (tick == TW'(GAMMA_LEN - 1));
      rtick_last = (rtick == RW'(REST_LEN - 1));
   end

   // Window sequencer with registered outputs; spikes are single-cycle pulses.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state              <= S_IDLE;
         tick               <= '0;
         rtick              <= '0;
         should_spike_out_l <= '1;
         fired_l            <= '1;
         spike_count        <= '0;
         inhibited          <= 1'b0;
         busy               <= 1'b0;
         gamma_done         <= 1'b0;
      end else begin
         should_spike_out_l <= '1;
         gamma_done         <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state       <= S_INTEGRATE;
                  tick        <= '0;
                  fired_l     <= '1;
                  spike_count <= '0;
                  busy        <= 1'b1;
                  inhibited   <= 1'b0;
               end
            end
            S_INTEGRATE: begin
               if (accept) begin
                  should_spike_out_l <= ~cand;
                  fired_l            <= fired_l & ~cand;
                  spike_count        <= sum;
               end
               // The last tick closes the window even if the budget was hit on it.
               if (tick_last) begin
                  state     <= S_REST;
                  rtick     <= '0;
                  inhibited <= 1'b0;
               end else begin
                  tick <= tick + 1'b1;
                  if (over || (accept && (sum == CW'(FFI_MAX)))) begin
                     state     <= S_INHIBIT;
                     inhibited <= 1'b1;
                  end
               end
            end
            S_INHIBIT: begin
               if (tick_last) begin
                  state     <= S_REST;
                  rtick     <= '0;
                  inhibited <= 1'b0;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            S_REST: begin
               if (rtick_last) begin
                  state      <= S_IDLE;
                  tick       <= '0;
                  rtick      <= '0;
                  busy       <= 1'b0;
                  gamma_done <= 1'b1;
               end else begin
                  rtick <= rtick + 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
